// File: rtl/spi_ram_if.sv
// Command/response bus between the SPI slave (master side) and spi_ram_ctrl (slave side).
interface spi_ram_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  modport master (output din, rx_valid, input dout, tx_valid, cmd_err);
  modport slave  (input din, rx_valid, output dout, tx_valid, cmd_err);
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave.
// Optional macro ADDR_AUTOINC_EN: post-increment addresses and allow streaming reads in TX.
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 2**ADDR_SIZE
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_ram_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, TX} state_t;

  localparam logic [1:0] OP_WA = 2'b00;
  localparam logic [1:0] OP_WD = 2'b01;
  localparam logic [1:0] OP_RA = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  state_t                 state_q, state_d;
  logic [7:0]             mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
  logic [7:0]             dout_q;
  logic                   err_q, err_d;
  logic                   wr_en, wa_ld, ra_ld, rd_load;
  logic [1:0]             op;
  logic [7:0]             payload;
  logic                   addr_ok;

  assign op      = bus.din[9:8];
  assign payload = bus.din[7:0];
  // Non-power-of-two depths leave holes in the address space; reject both those and stray high bits.
  assign addr_ok = (32'(payload) < MEM_DEPTH) && ((32'(payload) >> ADDR_SIZE) == 32'd0);

`ifdef ADDR_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] a);
    return (32'(a) == MEM_DEPTH - 1) ? '0 : a + 1'b1;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wa_ld   = 1'b0;
    ra_ld   = 1'b0;
    rd_load = 1'b0;
    if (bus.rx_valid) begin
      unique case (op)
        OP_WA: begin
          if (!addr_ok) err_d = 1'b1;
          else begin
            wa_ld = 1'b1;
            if (state_q == TX) state_d = IDLE;
          end
        end
        OP_WD: begin
          wr_en = 1'b1;
          if (state_q == TX) state_d = IDLE;
        end
        OP_RA: begin
          if (!addr_ok) err_d = 1'b1;
          else begin
            ra_ld   = 1'b1;
            state_d = ARMED;
          end
        end
        OP_RD: begin
          case (state_q)
            ARMED: begin
              rd_load = 1'b1;
              state_d = TX;
            end
            TX: begin
`ifdef ADDR_AUTOINC_EN
              rd_load = 1'b1;
`else
              err_d   = 1'b1;
              state_d = IDLE;
`endif
            end
            default: err_d = 1'b1;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_addr <= '0;
      rd_addr <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (wa_ld) wr_addr <= payload[ADDR_SIZE-1:0];
`ifdef ADDR_AUTOINC_EN
      else if (wr_en) wr_addr <= bump(wr_addr);
`endif
      if (ra_ld) rd_addr <= payload[ADDR_SIZE-1:0];
`ifdef ADDR_AUTOINC_EN
      else if (rd_load) rd_addr <= bump(rd_addr);
`endif
      if (rd_load) dout_q <= mem[rd_addr];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_addr] <= payload;
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = (state_q == TX);
  assign bus.cmd_err  = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: command-level model checked every cycle plus directed literal checks.
module tb_spi_ram_ctrl;

  localparam int DEPTH = 256;
`ifdef ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  spi_ram_if bus  ();
  spi_ram_if bus2 ();

  spi_ram_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  spi_ram_ctrl #(.ADDR_SIZE(4), .MEM_DEPTH(12)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Command-level model of the main instance (depth 256).
  logic [7:0] mem_m [DEPTH];
  int         m_wa, m_ra;
  bit         m_armed, exp_tx, exp_err;
  logic [7:0] exp_dout;

  task automatic model_cmd(input logic [9:0] d);
    int p = int'(d[7:0]);
    bit ok = (p < DEPTH);
    case (d[9:8])
      2'b00: if (!ok) exp_err = 1'b1; else begin m_wa = p; exp_tx = 1'b0; end
      2'b01: begin
        mem_m[m_wa] = d[7:0];
        if (AUTOINC) m_wa = (m_wa + 1) % DEPTH;
        exp_tx = 1'b0;
      end
      2'b10: if (!ok) exp_err = 1'b1; else begin m_ra = p; m_armed = 1'b1; exp_tx = 1'b0; end
      default: begin
        if (m_armed || (exp_tx && AUTOINC)) begin
          exp_dout = mem_m[m_ra];
          if (AUTOINC) m_ra = (m_ra + 1) % DEPTH;
          exp_tx  = 1'b1;
          m_armed = 1'b0;
        end else begin
          exp_err = 1'b1;
          exp_tx  = 1'b0;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wa = 0; m_ra = 0; m_armed = 1'b0;
      exp_tx = 1'b0; exp_dout = 8'h00; exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
      if (bus.rx_valid) model_cmd(bus.din);
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_dout", 32'(bus.dout), 32'(exp_dout));
      chk("cyc_tx_valid", 32'(bus.tx_valid), 32'(exp_tx));
      chk("cyc_cmd_err", 32'(bus.cmd_err), 32'(exp_err));
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input bit sel, input logic [9:0] d);
    if (!sel) begin bus.din = d; bus.rx_valid = 1'b1; end
    else      begin bus2.din = d; bus2.rx_valid = 1'b1; end
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    bus2.rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.din = '0;  bus.rx_valid = 1'b0;
    bus2.din = '0; bus2.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_dout", 32'(bus.dout), 32'h00);
    chk("rst_tx", 32'(bus.tx_valid), 32'h0);
    chk("rst_err", 32'(bus.cmd_err), 32'h0);
    chk("rst2_dout", 32'(bus2.dout), 32'h00);

    // Basic write then read
    send(0, 10'h000); send(0, 10'h1A5); send(0, 10'h200); send(0, 10'h3FF);
    chk("rd_a5_dout", 32'(bus.dout), 32'hA5);
    chk("rd_a5_tx", 32'(bus.tx_valid), 32'h1);
    repeat (20) @(negedge clk);
    chk("hold_dout", 32'(bus.dout), 32'hA5);
    chk("hold_tx", 32'(bus.tx_valid), 32'h1);
    send(0, 10'h000);
    chk("drop_tx", 32'(bus.tx_valid), 32'h0);

    // Read-data from reset is an error
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    send(0, 10'h3FF);
    chk("idle_rd_err", 32'(bus.cmd_err), 32'h1);
    chk("idle_rd_tx", 32'(bus.tx_valid), 32'h0);
    @(negedge clk);
    chk("err_one_cycle", 32'(bus.cmd_err), 32'h0);

    // Several addresses, re-arm from TX, second read-data in TX
    send(0, 10'h010); send(0, 10'h155); send(0, 10'h011); send(0, 10'h1AA);
    send(0, 10'h210); send(0, 10'h3FF);
    chk("rd_55", 32'(bus.dout), 32'h55);
    send(0, 10'h211); send(0, 10'h3FF);
    chk("rd_aa", 32'(bus.dout), 32'hAA);
    send(0, 10'h3FF);
    if (!AUTOINC) chk("tx_rd_err", 32'(bus.cmd_err), 32'h1);
    send(0, 10'h300);
    // Writes while armed keep the pending read address
    send(0, 10'h210); send(0, 10'h020); send(0, 10'h1CC); send(0, 10'h3FF);
    chk("armed_wr_keep", 32'(bus.dout), 32'h55);
    send(0, 10'h210); send(0, 10'h211); send(0, 10'h300);
    chk("ra_overwrite", 32'(bus.dout), 32'hAA);

    // Reset while a read is pending
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    chk("mid_rst_tx", 32'(bus.tx_valid), 32'h0);
    chk("mid_rst_dout", 32'(bus.dout), 32'h00);
    send(0, 10'h3A7);
    chk("post_rst_err", 32'(bus.cmd_err), 32'h1);

    // Range checking on a 12-word instance
    send(1, 10'h00C);
    chk("d2_range_err", 32'(bus2.cmd_err), 32'h1);
    @(negedge clk);
    chk("d2_err_clear", 32'(bus2.cmd_err), 32'h0);
    send(1, 10'h010);
    chk("d2_hibit_err", 32'(bus2.cmd_err), 32'h1);
    send(1, 10'h13C); send(1, 10'h200); send(1, 10'h3FF);
    chk("d2_mem0", 32'(bus2.dout), 32'h3C);
    chk("d2_tx", 32'(bus2.tx_valid), 32'h1);
    send(1, 10'h00B);
    chk("d2_top_ok", 32'(bus2.cmd_err), 32'h0);
    send(1, 10'h177); send(1, 10'h20B); send(1, 10'h20C);
    chk("d2_ra_err", 32'(bus2.cmd_err), 32'h1);
    send(1, 10'h3FF);
    chk("d2_armed_kept", 32'(bus2.dout), 32'h77);
    chk("d2_armed_tx", 32'(bus2.tx_valid), 32'h1);

    if (AUTOINC) begin
      send(0, 10'h0FE); send(0, 10'h111); send(0, 10'h122); send(0, 10'h133);
      send(0, 10'h2FE);
      send(0, 10'h300); chk("ai_rd0", 32'(bus.dout), 32'h11);
      send(0, 10'h300); chk("ai_rd1", 32'(bus.dout), 32'h22);
      send(0, 10'h300); chk("ai_rd2", 32'(bus.dout), 32'h33);
      chk("ai_no_err", 32'(bus.cmd_err), 32'h0);
      chk("ai_tx", 32'(bus.tx_valid), 32'h1);
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command-decoding single-port RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx word and rx_valid strobe.
- Executes write-address, write-data, read-address and read-data commands.
- Returns read bytes to the slave on dout/tx_valid for shifting out on MISO.
- Flags malformed command sequences on cmd_err.

Parameters:
ADDR_SIZE, 8, address width in bits (1..8); taken from din[ADDR_SIZE-1:0].
MEM_DEPTH, 2**ADDR_SIZE, number of 8-bit words; must not exceed 2**ADDR_SIZE.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, synchronous, active-low.
din  input  10  command word from SPI slave; [9:8] opcode, [7:0] payload.
rx_valid  input  1  single-cycle strobe; din valid this cycle.
dout  output  8  read data to SPI slave.
tx_valid  output  1  dout valid; held until consumed.
cmd_err  output  1  single-cycle error pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge): dout=0, tx_valid=0, cmd_err=0, wr_addr=0, rd_addr=0, state=IDLE. Memory contents are not reset. Reset mid-operation aborts any pending read and drops tx_valid on that same edge.
- Commands are acted on only at clk edges where rx_valid=1; din is ignored otherwise. One command per strobe.
- Opcodes:
  - 00 write-addr: wr_addr <= payload.
  - 01 write-data: mem[wr_addr] <= payload.
  - 10 read-addr: rd_addr <= payload.
  - 11 read-data: payload is a dummy byte and is ignored.
- Address range check: if payload >= MEM_DEPTH, or any payload bit above ADDR_SIZE-1 is set, on opcode 00 or 10:
  - The address register is not updated.
  - cmd_err pulses.
  - The state does not change.
- FSM states: IDLE (no read address loaded), ARMED (read address loaded), TX (dout valid).
  - IDLE: 10 -> ARMED; 11 -> cmd_err pulse, stay IDLE; 00/01 -> IDLE.
  - ARMED: 10 -> ARMED (rd_addr overwritten); 00/01 -> ARMED; 11 -> TX.
  - TX: any accepted command drops tx_valid on that edge. Next state: 10 -> ARMED; 11 -> cmd_err pulse, IDLE; 00/01 -> IDLE.
- Read latency: dout <= mem[rd_addr] and tx_valid <= 1 on the same edge that accepts read-data, so both are visible the cycle after the rx_valid strobe. dout and tx_valid remain stable until the next accepted command or reset.
- Read-data returns the memory value including all write-data commands accepted earlier.
- cmd_err is high for exactly one cycle per offending command. It is 0 otherwise.
- Write-data always writes; there are no full or empty conditions.

Optional Feature:
ADDR_AUTOINC_EN
- Defined:
  - After each accepted write-data, wr_addr increments, wrapping from MEM_DEPTH-1 to 0.
  - After each accepted read-data from ARMED, rd_addr increments with the same wrap.
  - 11 accepted in TX is legal: it loads dout from the incremented rd_addr, re-asserts tx_valid and stays in TX, giving a streaming read with no cmd_err.
- Undefined: addresses change only through opcodes 00/10; a second 11 in TX is an error as described above.

Test Plan:
- Reset, then rx_valid with din=0x000, din=0x1A5, din=0x200, din=0x3FF -> dout=0xA5 and tx_valid=1 the cycle after the fourth strobe; cmd_err stays 0.
- With tx_valid=1 and no further strobes for 20 cycles -> dout=0xA5 and tx_valid=1 throughout. Then strobe din=0x000 -> tx_valid=0 on that edge.
- From reset, strobe din=0x3FF -> cmd_err high for one cycle, tx_valid=0, state IDLE.
- ADDR_SIZE=4, MEM_DEPTH=12: strobe din=0x00C -> cmd_err pulse, wr_addr unchanged. Then din=0x13C -> mem[0]=0x3C.
- Read pending (tx_valid=1), assert rst_n=0 for one edge -> tx_valid=0, dout=0. Then strobe din=0x3xx -> cmd_err pulse.
- ADDR_AUTOINC_EN: write 0x11,0x22,0x33 from addr 0xFE with MEM_DEPTH=256, giving addr 0xFE, 0xFF, 0x00. Then read-addr 0xFE plus three read-data strobes -> dout 0x11, 0x22, 0x33; no cmd_err.
